// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALU ops, mux selects, the 4-bit state encoding and the control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_ONE    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_ALUWB   = 4'd8,
    S_BEQ     = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDI_EX = 4'd11,
    S_ADDI_WB = 4'd12
  } state_t;

  // pc_write is the unconditional PC load; branch is qualified by zero outside the register.
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] controlline;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation decode; o_valid flags a recognised funct.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic       o_valid
);

  always_comb begin
    o_alu_op = ALU_ADD;
    o_valid  = 1'b1;
    case (i_funct)
      FN_ADD:  o_alu_op = ALU_ADD;
      FN_SUB:  o_alu_op = ALU_SUB;
      FN_AND:  o_alu_op = ALU_AND;
      FN_OR:   o_alu_op = ALU_OR;
      FN_SLT:  o_alu_op = ALU_SLT;
      default: o_valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath.
// Define MULTICYCLE_CTRL_ADDI_EN to build the addi execute/writeback states.
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] controlline,
  output logic [1:0] PCSource,
  output logic [3:0] state
);

  state_t     r_state;
  state_t     w_next;
  ctrl_t      r_ctrl;
  ctrl_t      w_ctrl;
  logic [2:0] w_alu_op;
  logic       w_alu_valid;

  alu_decoder u_alu_decoder (
    .i_funct  (funct),
    .o_alu_op (w_alu_op),
    .o_valid  (w_alu_valid)
  );

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BEQ;
          OP_J:         w_next = S_JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
          OP_ADDI:      w_next = S_ADDI_EX;
`endif
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = S_FETCH;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BEQ:    w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
`ifdef MULTICYCLE_CTRL_ADDI_EN
      S_ADDI_EX: w_next = S_ADDI_WB;
      S_ADDI_WB: w_next = S_FETCH;
`endif
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded for the state being entered so they register alongside it.
  always_comb begin
    w_ctrl = '0;
    case (w_next)
      S_FETCH: begin
        w_ctrl.mem_read    = 1'b1;
        w_ctrl.ir_write    = 1'b1;
        w_ctrl.pc_write    = 1'b1;
        w_ctrl.alu_src_b   = SRCB_ONE;
        w_ctrl.controlline = ALU_ADD;
        w_ctrl.pc_source   = PCSRC_ALU;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b   = SRCB_IMM_SH;
        w_ctrl.controlline = ALU_ADD;
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a   = 1'b1;
        w_ctrl.alu_src_b   = SRCB_IMM;
        w_ctrl.controlline = ALU_ADD;
      end
      S_MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        w_ctrl.alu_src_a   = 1'b1;
        w_ctrl.alu_src_b   = SRCB_B;
        w_ctrl.controlline = w_alu_op;
      end
      S_ALUWB: begin
        w_ctrl.reg_write = w_alu_valid;
        w_ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        w_ctrl.alu_src_a   = 1'b1;
        w_ctrl.alu_src_b   = SRCB_B;
        w_ctrl.controlline = ALU_SUB;
        w_ctrl.pc_source   = PCSRC_ALUOUT;
        w_ctrl.branch      = 1'b1;
      end
      S_JUMP: begin
        w_ctrl.pc_source = PCSRC_JUMP;
        w_ctrl.pc_write  = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_ADDI_EN
      S_ADDI_EX: begin
        w_ctrl.alu_src_a   = 1'b1;
        w_ctrl.alu_src_b   = SRCB_IMM;
        w_ctrl.controlline = ALU_ADD;
      end
      S_ADDI_WB: begin
        w_ctrl.reg_write = 1'b1;
      end
`endif
      default: w_ctrl = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= w_ctrl;
    end
  end

  assign pc_en       = r_ctrl.pc_write | (r_ctrl.branch & zero);
  assign IorD        = r_ctrl.iord;
  assign MemRead     = r_ctrl.mem_read;
  assign MemWrite    = r_ctrl.mem_write;
  assign IRWrite     = r_ctrl.ir_write;
  assign RegDst      = r_ctrl.reg_dst;
  assign MemtoReg    = r_ctrl.mem_to_reg;
  assign RegWrite    = r_ctrl.reg_write;
  assign AluSrcA     = r_ctrl.alu_src_a;
  assign AluSrcB     = r_ctrl.alu_src_b;
  assign controlline = r_ctrl.controlline;
  assign PCSource    = r_ctrl.pc_source;
  assign state       = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-stream bench for multicycle_ctrl against a per-instruction
// path model built from the state/output table and cycles-per-instruction rules.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] ctl;
    logic [1:0] pcs;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, AluSrcA;
  logic [1:0] AluSrcB, PCSource;
  logic [2:0] controlline;
  logic [3:0] state;
  obs_t       w_obs;

  int checks = 0;
  int failures = 0;
  int force_zero = -1;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .controlline(controlline),
    .PCSource(PCSource), .state(state)
  );

  assign w_obs = {state, pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                  RegWrite, AluSrcA, AluSrcB, controlline, PCSource};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addi_built();
`ifdef MULTICYCLE_CTRL_ADDI_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Cycles per instruction class.
  function automatic int plen(input logic [5:0] op);
    case (op)
      6'b100011:                     return 5;
      6'b101011, 6'b000000:          return 4;
      6'b000100, 6'b000010:          return 3;
      6'b001000:                     return addi_built() ? 4 : 2;
      default:                       return 2;
    endcase
  endfunction

  // State visited in cycle i of an instruction.
  function automatic int pstate(input logic [5:0] op, input int i);
    if (i == 0) return 1;
    if (i == 1) return 2;
    case (op)
      6'b100011: return (i == 2) ? 3 : (i == 3) ? 4 : 5;
      6'b101011: return (i == 2) ? 3 : 6;
      6'b000000: return (i == 2) ? 7 : 8;
      6'b000100: return 9;
      6'b000010: return 10;
      default:   return (i == 2) ? 11 : 12;
    endcase
  endfunction

  function automatic obs_t model(input int st, input logic [5:0] fn, input logic z);
    obs_t e;
    logic       legal;
    logic [2:0] op;
    e = '0;
    e.st = 4'(st);
    legal = 1'b1;
    case (fn)
      6'b100000: op = 3'b010;
      6'b100010: op = 3'b110;
      6'b100100: op = 3'b000;
      6'b100101: op = 3'b001;
      6'b101010: op = 3'b111;
      default: begin op = 3'b010; legal = 1'b0; end
    endcase
    case (st)
      1:  begin e.pc_en = 1; e.mrd = 1; e.irw = 1; e.srcb = 2'b01; e.ctl = 3'b010; end
      2:  begin e.srcb = 2'b11; e.ctl = 3'b010; end
      3, 11: begin e.srca = 1; e.srcb = 2'b10; e.ctl = 3'b010; end
      4:  begin e.mrd = 1; e.iord = 1; end
      5:  begin e.rw = 1; e.m2r = 1; end
      6:  begin e.mwr = 1; e.iord = 1; end
      7:  begin e.srca = 1; e.ctl = op; end
      8:  begin e.rw = legal; e.rdst = 1; end
      9:  begin e.srca = 1; e.ctl = 3'b110; e.pcs = 2'b01; e.pc_en = z; end
      10: begin e.pcs = 2'b10; e.pc_en = 1; end
      12: begin e.rw = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    obs_t e;
    for (int i = 0; i < plen(op); i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        opcode = op;
        funct  = fn;
      end
      zero = (force_zero < 0) ? 1'($urandom_range(0, 1)) : 1'(force_zero);
      @(negedge clk);
      e = model(pstate(op, i), fn, zero);
      chk($sformatf("op%02h_fn%02h_c%0d_state", op, fn, i), 32'(state), 32'(e.st));
      chk($sformatf("op%02h_fn%02h_c%0d_ctrl", op, fn, i), 32'(w_obs), 32'(e));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [7];
    logic [5:0] fns [5];
    logic [5:0] op;
    logic [5:0] fn;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b000000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_c%0d_state", i), 32'(state), 32'd0);
      chk($sformatf("reset_c%0d_ctrl", i), 32'(w_obs), 32'd0);
    end
    reset = 1'b0;

    run_instr(6'b000000, 6'b100010);
    run_instr(6'b100011, 6'b000000);
    run_instr(6'b101011, 6'b000000);
    force_zero = 1;
    run_instr(6'b000100, 6'b000000);
    force_zero = 0;
    run_instr(6'b000100, 6'b000000);
    force_zero = -1;
    run_instr(6'b001000, 6'b000000);
    run_instr(6'b000010, 6'b000000);
    run_instr(6'b111111, 6'b000000);
    run_instr(6'b000000, 6'b111111);

    // Reset asserted while in MEMWR.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) opcode = 6'b101011;
    end
    @(negedge clk);
    chk("memwr_before_reset_state", 32'(state), 32'd6);
    chk("memwr_before_reset_memwrite", 32'(MemWrite), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("memwr_abort_memwrite", 32'(MemWrite), 32'd0);
    chk("memwr_abort_state", 32'(state), 32'd0);
    chk("memwr_abort_ctrl", 32'(w_obs), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 7) op = ops[$urandom_range(0, 6)];
      else op = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) fn = fns[$urandom_range(0, 4)];
      else fn = 6'($urandom_range(0, 63));
      run_instr(op, fn);
    end

    @(posedge clk);
    @(negedge clk);
    chk("final_fetch_state", 32'(state), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
